alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's 32-bit add/sub/mul ALU. Adds an unsigned divide, bitwise logic ops, per-op error flags and valid/ready flow control on both input and output. Add/sub/logic complete in one cycle. Multiply and divide are iterative, one bit per cycle, which keeps the block small. It sits between a command source and a result consumer, and either side may stall.

Parameters:
WIDTH, 32, operand/result width in bits (legal range 4..64)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override)

Ports:
aclk  in  1  clock, rising edge
areset  in  1  asynchronous, active-high reset
in_valid  in  1  command valid
in_ready  out  1  block can accept a command
value_a  in  WIDTH  operand A, unsigned
value_b  in  WIDTH  operand B, unsigned
func  in  3  0 add, 1 sub, 2 mul, 3 divu, 4 and, 5 or, 6 xor, 7 reserved
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  sum, difference, product low word, quotient or logic result
result_hi  out  WIDTH  product high word or remainder; 0 for all other ops
error  out  1  operation error flag, qualified by out_valid

Behaviour:
- Reset (async assert, sync release): state IDLE, out_valid=0, result=0, result_hi=0, error=0, counter=0. in_ready=0 while areset is high.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterative mul/div running; in_ready=0.
  - DONE: out_valid=1; in_ready=0.
- Accept occurs when in_valid && in_ready at a rising edge. value_a, value_b and func are registered at that edge; later changes to them are ignored.
- Transitions for add, sub, logic ops, divide-by-zero and func=7: IDLE -> DONE at the accept edge. out_valid is high in the next cycle (latency 1).
- Transitions for mul and divu with b!=0: IDLE -> BUSY at the accept edge. WIDTH iteration edges follow; the WIDTH-th edge moves BUSY -> DONE. out_valid therefore rises exactly WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
- DONE -> IDLE on the edge where out_ready=1. While out_ready=0, result, result_hi and error hold stable and out_valid stays high.
- in_ready is high only in IDLE, so the sustained rate for single-cycle ops is one op per 2 cycles. out_ready is a don't-care outside DONE.
- add: result = (a+b) mod 2^WIDTH; error = carry-out.
- sub: result = (a-b) mod 2^WIDTH; error = borrow (a<b).
- mul: unsigned shift-add over a 2*WIDTH product; {result_hi,result} = a*b; error = (result_hi != 0).
- divu: restoring division. result = a/b, result_hi = a%b, error=0.
- divu with b=0: result = all ones, result_hi = a, error=1, latency 1 (no iterations run).
- and/or/xor: bitwise result, error=0.
- func=7: result=0, result_hi=0, error=1.
- Boundary cases (no special-casing in the datapath):
  - a=0 or b=0 on mul: full WIDTH iterations, product 0, error 0.
  - a<b on divu: quotient 0, remainder a.
  - max*max on mul: hi = 2^WIDTH-2, lo = 1, error 1.
- areset during BUSY or DONE aborts the operation and discards the result. After release the block is back in IDLE with all outputs 0.
- in_valid may be held high continuously; exactly one command is accepted per IDLE visit.

Decomposition:
- Package alu_pkg holds:
  - func code localparams: FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIVU, FUNC_AND, FUNC_OR, FUNC_XOR;
  - state encoding: ST_IDLE, ST_BUSY, ST_DONE.
- One sub-module, alu_seq_muldiv, is natural. It is the iterative engine: shared 2*WIDTH accumulator/shift register plus counter, with start/mode inputs, done pulse, and hi/lo outputs.
- The top level holds the FSM, handshake and single-cycle datapath.

Test Plan:
1. WIDTH=32, add 0xFFFFFFFF+0x00000001 -> result 0x00000000, error 1, out_valid exactly 1 cycle after accept; sub 5-7 -> 0xFFFFFFFE, error 1.
2. mul 0x00010000*0x00010000 -> result 0, result_hi 0x00000001, error 1, out_valid exactly 33 cycles after accept; mul 0xFFFFFFFF*0xFFFFFFFF -> hi 0xFFFFFFFE, lo 0x00000001.
3. divu 100/7 -> result 14, result_hi 2, error 0, latency 33; divu 0x1234/0 -> result 0xFFFFFFFF, result_hi 0x1234, error 1, latency 1.
4. Backpressure: hold out_ready=0 for 10 cycles after a mul completes -> outputs stable, in_ready 0, a concurrently held in_valid not accepted. Release out_ready -> in_ready returns 1 in the next cycle, and the held command is accepted.
5. Assert areset for 1 cycle at iteration 10 of a mul -> out_valid 0 and all outputs 0 immediately (async). A following xor 0xF0F0F0F0^0xFF00FF00 -> 0x0FF00FF0, error 0.
6. WIDTH=8 regression: 200+100 -> 44 with error 1; 15*17 -> {hi,lo}={0x00,0xFF}, error 0, latency 9; func=7 -> result 0, error 1.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the handshaked sequential ALU (alu_seq) and its
// iterative multiply/divide engine (alu_seq_muldiv).
//   FUNC_*  : 3-bit operation codes carried on the alu_seq 'func' port
//   ST_*    : control FSM state encoding used by alu_seq
//   startsEngine() : tells whether an opcode needs the iterative engine
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] FUNC_ADD  = 3'd0;
    localparam logic [2:0] FUNC_SUB  = 3'd1;
    localparam logic [2:0] FUNC_MUL  = 3'd2;
    localparam logic [2:0] FUNC_DIVU = 3'd3;
    localparam logic [2:0] FUNC_AND  = 3'd4;
    localparam logic [2:0] FUNC_OR   = 3'd5;
    localparam logic [2:0] FUNC_XOR  = 3'd6;
    localparam logic [2:0] FUNC_RSVD = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Divide by zero is answered immediately by the single-cycle path, so
    // only multiply and a real divide ever occupy the iterative engine.
    function automatic logic startsEngine(input logic [2:0] f, input logic bIsZero);
        return (f == FUNC_MUL) || ((f == FUNC_DIVU) && !bIsZero);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// -----------------------------------------------------------------------------
// alu_seq_muldiv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// clock, sharing a single 2*WIDTH accumulator and an iteration counter.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_start        : load operands and begin WIDTH iterations
//   i_divMode      : 0 = multiply, 1 = divide (sampled with i_start)
//   i_a, i_b       : operands (multiplier/multiplicand, dividend/divisor)
//   o_done         : high during the cycle whose closing edge is the last
//                    iteration
//   o_hi, o_lo     : product {hi,lo}, or remainder (hi) / quotient (lo)
// -----------------------------------------------------------------------------
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_divMode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_divMode;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_remDiff;
    logic [2*WIDTH-1:0] w_accNext;

    // One iteration step for either mode.
    // Multiply: the low half holds the remaining multiplier bits; add the
    // multiplicand into the high half when the current bit is set, then shift
    // the whole accumulator right (the carry becomes the new top bit).
    // Divide: the high half is the partial remainder, the low half the
    // dividend being shifted out while quotient bits shift in. The shifted
    // remainder needs WIDTH+1 bits, and the top bit of the trial difference is
    // a clean borrow because the remainder is always below the divisor.
    always_comb begin
        w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_remDiff  = w_remShift - {1'b0, r_b};
        if (!r_divMode) begin
            w_accNext = {w_mulSum, r_acc[WIDTH-1:1]};
        end else if (!w_remDiff[WIDTH]) begin
            w_accNext = {w_remDiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_accNext = {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
    end

    // Both modes start from {0, a}: zero partial product / zero remainder in
    // the high half, multiplier / dividend in the low half.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc     <= '0;
            r_b       <= '0;
            r_divMode <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
        end else if (i_start) begin
            r_acc     <= {{WIDTH{1'b0}}, i_a};
            r_b       <= i_b;
            r_divMode <= i_divMode;
            r_busy    <= 1'b1;
            r_cnt     <= CNT_W'(WIDTH);
        end else if (r_busy) begin
            r_acc <= w_accNext;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == CNT_W'(1));
    assign o_hi   = r_acc[2*WIDTH-1:WIDTH];
    assign o_lo   = r_acc[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked ALU: add/sub/and/or/xor in one cycle, iterative unsigned
// multiply and divide (one bit per clock) via alu_seq_muldiv.
// Ports:
//   aclk, areset        : clock, asynchronous active-high reset
//   in_valid / in_ready : command handshake (one command per IDLE visit)
//   value_a, value_b    : unsigned operands
//   func                : operation code (see alu_pkg FUNC_*)
//   out_valid/out_ready : result handshake; outputs hold while stalled
//   result, result_hi   : low word / quotient, high word / remainder
//   error               : carry, borrow, mul overflow, div-by-zero, reserved op
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] value_a,
    input  logic [WIDTH-1:0] value_b,
    input  logic [2:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             error
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_resultHi;
    logic             r_error;
    logic             r_fromEngine;
    logic             r_engineMul;

    logic             w_accept;
    logic             w_startEngine;
    logic             w_engDone;
    logic [WIDTH-1:0] w_engHi;
    logic [WIDTH-1:0] w_engLo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_fastLo;
    logic [WIDTH-1:0] w_fastHi;
    logic             w_fastErr;

    assign w_accept      = in_valid && in_ready;
    assign w_startEngine = w_accept && startsEngine(func, value_b == '0);

    // The engine samples operands on the accept edge itself, so the BUSY
    // countdown starts immediately after acceptance.
    alu_seq_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .i_clk     (aclk),
        .i_rst     (areset),
        .i_start   (w_startEngine),
        .i_divMode (func == FUNC_DIVU),
        .i_a       (value_a),
        .i_b       (value_b),
        .o_done    (w_engDone),
        .o_hi      (w_engHi),
        .o_lo      (w_engLo)
    );

    // Single-cycle results, computed from the live inputs and captured on the
    // accept edge. The extra top bit of the sum/difference is the carry/borrow.
    // The DIVU entry is only ever captured for a zero divisor.
    always_comb begin
        w_sum     = {1'b0, value_a} + {1'b0, value_b};
        w_diff    = {1'b0, value_a} - {1'b0, value_b};
        w_fastLo  = '0;
        w_fastHi  = '0;
        w_fastErr = 1'b0;
        case (func)
            FUNC_ADD: begin
                w_fastLo  = w_sum[WIDTH-1:0];
                w_fastErr = w_sum[WIDTH];
            end
            FUNC_SUB: begin
                w_fastLo  = w_diff[WIDTH-1:0];
                w_fastErr = w_diff[WIDTH];
            end
            FUNC_DIVU: begin
                w_fastLo  = '1;
                w_fastHi  = value_a;
                w_fastErr = 1'b1;
            end
            FUNC_AND: w_fastLo = value_a & value_b;
            FUNC_OR:  w_fastLo = value_a | value_b;
            FUNC_XOR: w_fastLo = value_a ^ value_b;
            default:  w_fastErr = 1'b1;
        endcase
    end

    // Control FSM. Engine results are not copied into r_result; instead the
    // output mux reads the engine accumulator directly, which stays frozen
    // once the iterations finish, so stalled outputs hold without extra
    // storage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_result     <= '0;
            r_resultHi   <= '0;
            r_error      <= 1'b0;
            r_fromEngine <= 1'b0;
            r_engineMul  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_startEngine) begin
                            r_state      <= ST_BUSY;
                            r_fromEngine <= 1'b1;
                            r_engineMul  <= (func == FUNC_MUL);
                        end else begin
                            r_state      <= ST_DONE;
                            r_fromEngine <= 1'b0;
                            r_result     <= w_fastLo;
                            r_resultHi   <= w_fastHi;
                            r_error      <= w_fastErr;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_engDone) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !areset;
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_fromEngine ? w_engLo : r_result;
    assign result_hi = r_fromEngine ? w_engHi : r_resultHi;
    assign error     = r_fromEngine ? (r_engineMul && (w_engHi != '0)) : r_error;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Scoreboarded bench for alu_seq at WIDTH=32 plus a small WIDTH=8 instance.
// Expected responses come from an arithmetic reference model and are queued
// at command acceptance; a monitor pops and compares when out_valid appears.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W  = 32;
    localparam int W8 = 8;

    typedef struct {
        logic [63:0] lo;
        logic [63:0] hi;
        logic        err;
        int          lat;
        int          acceptCycle;
    } exp_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  value_a;
    logic [W-1:0]  value_b;
    logic [2:0]    func;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          error;

    logic          in_valid8;
    logic          in_ready8;
    logic [W8-1:0] value_a8;
    logic [W8-1:0] value_b8;
    logic [2:0]    func8;
    logic          out_valid8;
    logic          out_ready8 = 1'b1;
    logic [W8-1:0] result8;
    logic [W8-1:0] result_hi8;
    logic          error8;

    exp_t expQ[$];
    exp_t cur;
    bit   holding     = 1'b0;
    bit   randReady   = 1'b0;
    bit   forcedReady = 1'b1;
    int   nChecks     = 0;
    int   nFails      = 0;
    int   cycle       = 0;

    alu_seq #(.WIDTH(W)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value_a   (value_a),
        .value_b   (value_b),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .error     (error)
    );

    alu_seq #(.WIDTH(W8)) dut8 (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .value_a   (value_a8),
        .value_b   (value_b8),
        .func      (func8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .result    (result8),
        .result_hi (result_hi8),
        .error     (error8)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cycle <= cycle + 1;

    // Consumer readiness: either random backpressure or a level set by the
    // main sequence; updated 2 time units after the edge.
    always @(posedge aclk) begin
        #2;
        out_ready = randReady ? ($urandom_range(0, 3) != 0) : forcedReady;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic, truncated to w bits.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic [2:0] f);
        exp_t        m;
        logic [63:0] mask;
        logic [63:0] s;
        logic [63:0] p;
        mask          = (64'd1 << w) - 64'd1;
        m.lo          = 64'd0;
        m.hi          = 64'd0;
        m.err         = 1'b0;
        m.lat         = 1;
        m.acceptCycle = 0;
        case (f)
            3'd0: begin
                s     = a + b;
                m.lo  = s & mask;
                m.err = ((s >> w) != 64'd0);
            end
            3'd1: begin
                m.lo  = (a - b) & mask;
                m.err = (a < b);
            end
            3'd2: begin
                p     = a * b;
                m.lo  = p & mask;
                m.hi  = (p >> w) & mask;
                m.err = (m.hi != 64'd0);
                m.lat = w + 1;
            end
            3'd3: begin
                if (b == 64'd0) begin
                    m.lo  = mask;
                    m.hi  = a;
                    m.err = 1'b1;
                end else begin
                    m.lo  = a / b;
                    m.hi  = a % b;
                    m.lat = w + 1;
                end
            end
            3'd4: m.lo = a & b;
            3'd5: m.lo = a | b;
            3'd6: m.lo = a ^ b;
            default: m.err = 1'b1;
        endcase
        return m;
    endfunction

    // Issue one command on the 32-bit DUT; called at posedge+1, returns at
    // posedge+1 just after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        exp_t e;
        int   waited = 0;
        value_a  = a;
        value_b  = b;
        func     = f;
        in_valid = 1'b1;
        while (!in_ready && waited < 600) begin
            @(posedge aclk); #1;
            waited++;
        end
        if (!in_ready) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 600 cycles");
            in_valid = 1'b0;
            return;
        end
        e             = model(W, 64'(a), 64'(b), f);
        e.acceptCycle = cycle + 1;
        expQ.push_back(e);
        @(posedge aclk); #1;
        in_valid = 1'b0;
        value_a  = $urandom;
        value_b  = $urandom;
        func     = 3'($urandom_range(0, 7));
    endtask

    task automatic waitIdle();
        int waited = 0;
        while ((expQ.size() != 0 || holding || !in_ready) && waited < 600) begin
            @(posedge aclk); #1;
            waited++;
        end
        if (waited >= 600) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL idle_timeout: got %0d pending results, expected 0", expQ.size());
        end
    endtask

    // Directed check on the WIDTH=8 instance (consumer always ready).
    task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic [2:0] f);
        exp_t e;
        int   acc;
        int   waited = 0;
        e         = model(W8, 64'(a), 64'(b), f);
        value_a8  = a;
        value_b8  = b;
        func8     = f;
        in_valid8 = 1'b1;
        while (!in_ready8 && waited < 50) begin
            @(posedge aclk); #1;
            waited++;
        end
        acc = cycle + 1;
        @(posedge aclk); #1;
        in_valid8 = 1'b0;
        value_a8  = 8'($urandom);
        value_b8  = 8'($urandom);
        waited    = 0;
        while (!out_valid8 && waited < 50) begin
            @(posedge aclk); #1;
            waited++;
        end
        checkOutput("w8_latency", 64'(cycle - acc + 1), 64'(e.lat));
        checkOutput("w8_result", 64'(result8), e.lo);
        checkOutput("w8_result_hi", 64'(result_hi8), e.hi);
        checkOutput("w8_error", 64'(error8), 64'(e.err));
        @(posedge aclk); #1;
    endtask

    // Monitor: first cycle of out_valid pops the expectation and checks data
    // and latency; further stalled cycles re-check that outputs hold.
    always @(negedge aclk) begin
        if (!areset && out_valid) begin
            if (!holding) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_result: got result 0x%0h, expected no result", result);
                end else begin
                    cur     = expQ.pop_front();
                    holding = 1'b1;
                    checkOutput("latency", 64'(cycle - cur.acceptCycle + 1), 64'(cur.lat));
                    checkOutput("result", 64'(result), cur.lo);
                    checkOutput("result_hi", 64'(result_hi), cur.hi);
                    checkOutput("error", 64'(error), 64'(cur.err));
                end
            end else begin
                checkOutput("held_result", 64'(result), cur.lo);
                checkOutput("held_result_hi", 64'(result_hi), cur.hi);
                checkOutput("held_error", 64'(error), 64'(cur.err));
            end
            if (out_ready) holding = 1'b0;
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rf;
        areset    = 1'b1;
        in_valid  = 1'b0;
        value_a   = '0;
        value_b   = '0;
        func      = 3'd0;
        in_valid8 = 1'b0;
        value_a8  = '0;
        value_b8  = '0;
        func8     = 3'd0;

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_result_hi", 64'(result_hi), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

        // Single-cycle ops and boundaries
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 3'd0);
        applyStimulus(32'd5, 32'd7, 3'd1);
        applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4);
        applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5);
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 3'd7);

        // Iterative ops and boundaries
        applyStimulus(32'h0001_0000, 32'h0001_0000, 3'd2);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2);
        applyStimulus(32'd0, 32'd12345, 3'd2);
        applyStimulus(32'd100, 32'd7, 3'd3);
        applyStimulus(32'h0000_1234, 32'd0, 3'd3);
        applyStimulus(32'd5, 32'd9, 3'd3);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'd3);
        waitIdle();

        // Backpressure with a second command held on the input
        forcedReady = 1'b0;
        applyStimulus(32'h1234_5678, 32'h0009_ABCD, 3'd2);
        value_a  = 32'hAAAA_5555;
        value_b  = 32'h0F0F_0F0F;
        func     = 3'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !out_valid; i++) begin
            @(posedge aclk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge aclk); #1;
        end
        forcedReady = 1'b1;
        @(posedge aclk); #1;
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(32'hAAAA_5555, 32'h0F0F_0F0F, 3'd6);
        waitIdle();

        // Abort a multiply part-way through
        applyStimulus(32'hDEAD_BEEF, 32'h0000_1001, 3'd2);
        repeat (10) begin
            @(posedge aclk); #1;
        end
        areset = 1'b1;
        #1;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
        checkOutput("abort_result", 64'(result), 64'd0);
        checkOutput("abort_result_hi", 64'(result_hi), 64'd0);
        checkOutput("abort_error", 64'(error), 64'd0);
        expQ.delete();
        holding = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        checkOutput("post_abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("post_abort_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6);
        waitIdle();

        // Narrow instance
        run8(8'd200, 8'd100, 3'd0);
        run8(8'd15, 8'd17, 3'd2);
        run8(8'hFF, 8'hFF, 3'd2);
        run8(8'd200, 8'd7, 3'd3);
        run8(8'd3, 8'd5, 3'd7);

        // Random traffic with random consumer stalls
        randReady = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0:       ra = '0;
                1:       ra = '1;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            rf = 3'($urandom_range(0, 7));
            applyStimulus(ra, rb, rf);
        end
        randReady   = 1'b0;
        forcedReady = 1'b1;
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
